div_unit: RTL

Iterative RV32M divide/remainder unit serving the `DIV`, `DIVU`, `REM` and `REMU` instructions. It sits beside the load/store stage. It receives operands from EXE, runs a 32-step restoring division, and writes the result back through the LSU→WRB path. It also drives `type_div2fwd_s` (`div_req`, `div_ack`) into the pipeline forward/stall controller, which holds the pipeline while the operation is in flight.

---
 rtl/div_unit.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/div_unit.sv
// Iterative RV32M DIV/DIVU/REM/REMU unit, 32-step restoring division.
// Optional macro DIV_EARLY_OUT_EN: zero divisor / signed overflow skip ITER.
module div_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            div_start_i,
    input  logic [1:0]      div_op_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    input  logic [4:0]      rd_addr_i,
    input  logic            flush_i,
    output logic [1:0]      div2fwd_o,
    output logic [XLEN-1:0] div_result_o,
    output logic [4:0]      div_rd_addr_o,
    output logic            div_wr_req_o
);

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        DONE
    } state_t;

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t          state;
    logic [4:0]      cnt;
    logic            op_rem;
    logic            neg_q;
    logic            neg_r;
    logic            div_zero;
    logic            ovf;
    logic            div_req;
    logic [4:0]      rd_addr;
    logic [XLEN-1:0] rs1_raw;
    logic [XLEN-1:0] divisor;
    logic [XLEN-1:0] rem;
    logic [XLEN-1:0] quo;

    logic            is_signed;
    logic            s1;
    logic            s2;
    logic [XLEN-1:0] abs1;
    logic [XLEN-1:0] abs2;
    logic            start_zero;
    logic            start_ovf;
    logic [XLEN+1:0] trial;
    logic [XLEN-1:0] q_fix;
    logic [XLEN-1:0] r_fix;
    logic [XLEN-1:0] res;
    logic            div_ack;

    assign is_signed  = ~div_op_i[0];
    assign s1         = is_signed & rs1_data_i[XLEN-1];
    assign s2         = is_signed & rs2_data_i[XLEN-1];
    assign abs1       = s1 ? (~rs1_data_i + 1'b1) : rs1_data_i;
    assign abs2       = s2 ? (~rs2_data_i + 1'b1) : rs2_data_i;
    assign start_zero = (rs2_data_i == '0);
    assign start_ovf  = is_signed & (rs1_data_i == MIN_NEG) & (&rs2_data_i);

    // trial subtract on the shifted partial remainder; extra top bit is the sign
    assign trial = {1'b0, rem, quo[XLEN-1]} - {2'b00, divisor};

    assign q_fix = neg_q ? (~quo + 1'b1) : quo;
    assign r_fix = neg_r ? (~rem + 1'b1) : rem;

    // final result select with forced special-case values
    always_comb begin
        res = op_rem ? r_fix : q_fix;
        if (div_zero) begin
            res = op_rem ? rs1_raw : '1;
        end else if (ovf) begin
            res = op_rem ? '0 : MIN_NEG;
        end
    end

    assign div_ack      = (state == DONE) & ~flush_i;
    assign div_wr_req_o = div_ack;
    assign div2fwd_o    = {div_req, div_ack};
    assign div_result_o = (state == DONE) ? res : '0;
    assign div_rd_addr_o = rd_addr;

    // control FSM and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            op_rem   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            ovf      <= 1'b0;
            div_req  <= 1'b0;
            rd_addr  <= '0;
            rs1_raw  <= '0;
            divisor  <= '0;
            rem      <= '0;
            quo      <= '0;
        end else if (flush_i) begin
            state   <= IDLE;
            div_req <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (div_start_i) begin
                        op_rem   <= div_op_i[1];
                        neg_q    <= s1 ^ s2;
                        neg_r    <= s1;
                        div_zero <= start_zero;
                        ovf      <= start_ovf;
                        rd_addr  <= rd_addr_i;
                        rs1_raw  <= rs1_data_i;
                        divisor  <= abs2;
                        quo      <= abs1;
                        rem      <= '0;
                        cnt      <= 5'd31;
                        div_req  <= 1'b1;
`ifdef DIV_EARLY_OUT_EN
                        state    <= (start_zero | start_ovf) ? DONE : ITER;
`else
                        state    <= ITER;
`endif
                    end
                end
                ITER: begin
                    if (!trial[XLEN+1]) begin
                        rem <= trial[XLEN-1:0];
                        quo <= {quo[XLEN-2:0], 1'b1};
                    end else begin
                        rem <= {rem[XLEN-2:0], quo[XLEN-1]};
                        quo <= {quo[XLEN-2:0], 1'b0};
                    end
                    if (cnt == 5'd0) begin
                        state <= DONE;
                    end else begin
                        cnt <= cnt - 5'd1;
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    div_req <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    div_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
